alu_dispatch: RTL and testbench

Command buffer and issue stage directly upstream of `alu`. Accepts tagged operations `{a, b, cmd, tag}` from the decode side into a small FIFO and issues them one at a time to the ALU. It tracks the single outstanding operation and presents the tagged result to writeback through a valid/ready handshake. Divide-by-zero is intercepted here and never reaches the ALU.

---
 rtl/alu_dispatch_pkg.sv | 27 ++
 rtl/alu_dispatch_cmd_fifo.sv | 59 +++++
 rtl/alu_dispatch.sv | 139 +++++++++++++
 tb/tb_alu_dispatch.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_dispatch_pkg.sv
// Shared definitions for the ALU command dispatcher: opcodes, the
// divide-by-zero result pattern, FSM state type and a decode helper.
package alu_dispatch_pkg;

   localparam logic [2:0]  OP_ADD = 3'd0;
   localparam logic [2:0]  OP_SUB = 3'd1;
   localparam logic [2:0]  OP_AND = 3'd2;
   localparam logic [2:0]  OP_OR  = 3'd3;
   localparam logic [2:0]  OP_XOR = 3'd4;
   localparam logic [2:0]  OP_SLL = 3'd5;
   localparam logic [2:0]  OP_SRL = 3'd6;
   localparam logic [2:0]  OP_DIV = 3'd7;

   localparam logic [31:0] DIVZERO_RESULT = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   // A divide with a zero divisor is answered locally instead of issued.
   function automatic logic is_divzero(input logic [2:0] cmd, input logic [31:0] b);
      return (cmd == OP_DIV) && (b == 32'd0);
   endfunction

endpackage

// File: rtl/alu_dispatch_cmd_fifo.sv
// Synchronous command FIFO. Push is refused while full even when a pop
// happens on the same edge; pointers wrap naturally (DEPTH is a power of two).
module alu_dispatch_cmd_fifo #(
   parameter int WIDTH = 71,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         i_push,
   input  logic [WIDTH-1:0]             i_wdata,
   input  logic                         i_pop,
   output logic [WIDTH-1:0]             o_rdata,
   output logic                         o_full,
   output logic                         o_empty,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_rdata = r_mem[r_rptr];
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;

   // Entry storage; payload needs no reset since occupancy gates its use.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= i_wdata;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/alu_dispatch.sv
// Command buffer and issue stage ahead of the ALU. Queues tagged commands,
// issues one at a time, intercepts divide-by-zero, and hands the tagged
// result to writeback over a valid/ready handshake.
module alu_dispatch #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         i_valid,
   input  logic [31:0]                  i_a,
   input  logic [31:0]                  i_b,
   input  logic [2:0]                   i_cmd,
   input  logic [TAG_W-1:0]             i_tag,
   output logic                         o_ready,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic [31:0]                  o_alu_a,
   output logic [31:0]                  o_alu_b,
   output logic [2:0]                   o_alu_cmd,
   output logic                         o_alu_start,
   input  logic                         i_alu_ready,
   input  logic                         i_alu_valid,
   input  logic [31:0]                  i_alu_result,
   output logic                         o_res_valid,
   output logic [31:0]                  o_res_data,
   output logic [TAG_W-1:0]             o_res_tag,
   output logic                         o_res_err,
   input  logic                         i_res_ready
);

   import alu_dispatch_pkg::*;

   localparam int ENTRY_W = 67 + TAG_W;

   state_t             r_state;
   logic [31:0]        r_alu_a;
   logic [31:0]        r_alu_b;
   logic [2:0]         r_alu_cmd;
   logic               r_alu_start;
   logic [TAG_W-1:0]   r_tag;
   logic               r_res_valid;
   logic [31:0]        r_res_data;
   logic [TAG_W-1:0]   r_res_tag;
   logic               r_res_err;

   logic [ENTRY_W-1:0] w_head;
   logic [31:0]        w_head_a;
   logic [31:0]        w_head_b;
   logic [2:0]         w_head_cmd;
   logic [TAG_W-1:0]   w_head_tag;
   logic               w_full;
   logic               w_empty;
   logic               w_pop;

   assign {w_head_a, w_head_b, w_head_cmd, w_head_tag} = w_head;

   // Pop only when nothing is outstanding and the ALU can take work.
   assign w_pop   = (r_state == ST_IDLE) & ~w_empty & i_alu_ready;
   assign o_ready = ~w_full;

   alu_dispatch_cmd_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_cmd_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (i_valid),
      .i_wdata ({i_a, i_b, i_cmd, i_tag}),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (o_count)
   );

   // Issue FSM: IDLE pops and issues, BUSY waits for the ALU, HOLD offers the result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_cmd   <= '0;
         r_alu_start <= 1'b0;
         r_tag       <= '0;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
         r_res_tag   <= '0;
         r_res_err   <= 1'b0;
      end else begin
         r_alu_start <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_alu_a   <= w_head_a;
                  r_alu_b   <= w_head_b;
                  r_alu_cmd <= w_head_cmd;
                  r_tag     <= w_head_tag;
                  if (is_divzero(w_head_cmd, w_head_b)) begin
                     r_res_data  <= DIVZERO_RESULT;
                     r_res_err   <= 1'b1;
                     r_res_valid <= 1'b1;
                     r_res_tag   <= w_head_tag;
                     r_state     <= ST_HOLD;
                  end else begin
                     r_alu_start <= 1'b1;
                     r_state     <= ST_BUSY;
                  end
               end
            end
            ST_BUSY: begin
               if (i_alu_valid) begin
                  r_res_data  <= i_alu_result;
                  r_res_err   <= 1'b0;
                  r_res_valid <= 1'b1;
                  r_res_tag   <= r_tag;
                  r_state     <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (i_res_ready) begin
                  r_res_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_alu_a     = r_alu_a;
   assign o_alu_b     = r_alu_b;
   assign o_alu_cmd   = r_alu_cmd;
   assign o_alu_start = r_alu_start;
   assign o_res_valid = r_res_valid;
   assign o_res_data  = r_res_data;
   assign o_res_tag   = r_res_tag;
   assign o_res_err   = r_res_err;

endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: behavioural ALU with variable latency, a queue-based
// reference of the dispatcher, directed scenarios and randomized traffic.
`timescale 1ns/1ps
module tb_alu_dispatch;
   import alu_dispatch_pkg::*;

   localparam int DEPTH = 4;
   localparam int TAG_W = 4;
   localparam int CW    = $clog2(DEPTH+1);

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              i_valid;
   logic [31:0]       i_a, i_b;
   logic [2:0]        i_cmd;
   logic [TAG_W-1:0]  i_tag;
   logic              o_ready;
   logic [CW-1:0]     o_count;
   logic [31:0]       o_alu_a, o_alu_b;
   logic [2:0]        o_alu_cmd;
   logic              o_alu_start;
   logic              i_alu_ready, i_alu_valid;
   logic [31:0]       i_alu_result;
   logic              o_res_valid;
   logic [31:0]       o_res_data;
   logic [TAG_W-1:0]  o_res_tag;
   logic              o_res_err;
   logic              i_res_ready;

   alu_dispatch #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .reset(reset), .i_valid(i_valid), .i_a(i_a), .i_b(i_b),
      .i_cmd(i_cmd), .i_tag(i_tag), .o_ready(o_ready), .o_count(o_count),
      .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_cmd(o_alu_cmd),
      .o_alu_start(o_alu_start), .i_alu_ready(i_alu_ready),
      .i_alu_valid(i_alu_valid), .i_alu_result(i_alu_result),
      .o_res_valid(o_res_valid), .o_res_data(o_res_data),
      .o_res_tag(o_res_tag), .o_res_err(o_res_err), .i_res_ready(i_res_ready)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0]      a;
      logic [31:0]      b;
      logic [2:0]       cmd;
      logic [TAG_W-1:0] tag;
   } cmd_s;

   int               n_chk = 0;
   int               n_err = 0;
   // reference state: queued commands, the one in flight, the offered result
   cmd_s             m_q[$];
   cmd_s             m_cur;
   bit               m_out, m_resv, m_start;
   logic [31:0]      m_rdata;
   logic [TAG_W-1:0] m_rtag;
   logic             m_rerr;
   // behavioural ALU
   bit               alu_busy, alu_hold;
   int               alu_rem, alu_lat;
   // observation bookkeeping
   int               n_starts;
   bit               last_push_ok;
   logic [TAG_W-1:0] hs_tags[$];
   logic [31:0]      last_data;
   logic             last_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
      case (c)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_SLL:  return a << b[4:0];
         OP_SRL:  return a >> b[4:0];
         OP_DIV:  return (b == 32'd0) ? DIVZERO_RESULT : a / b;
         default: return 32'd0;
      endcase
   endfunction

   task automatic set_hold(input bit h);
      alu_hold    = h;
      i_alu_ready = !alu_busy && !alu_hold;
   endtask

   // One clock: sample pre-edge, advance reference and ALU, then compare.
   task automatic tick();
      bit          p_push, p_pop, p_hs, p_av, p_st, p_alu_v;
      cmd_s        p_cmd, head;
      logic [31:0] p_a, p_b;
      logic [2:0]  p_c;
      p_push  = i_valid && (m_q.size() < DEPTH);
      p_cmd   = {i_a, i_b, i_cmd, i_tag};
      p_pop   = !m_out && (m_q.size() != 0) && i_alu_ready;
      p_hs    = m_resv && i_res_ready;
      p_av    = i_alu_valid && m_out && !m_resv;
      p_st    = o_alu_start;
      p_alu_v = i_alu_valid;
      p_a = o_alu_a; p_b = o_alu_b; p_c = o_alu_cmd;
      if (o_res_valid && i_res_ready) begin
         hs_tags.push_back(o_res_tag);
         last_data = o_res_data;
         last_err  = o_res_err;
      end
      @(posedge clk);
      #1;
      last_push_ok = p_push;
      m_start = 0;
      if (p_hs) begin m_resv = 0; m_out = 0; end
      if (p_av) begin
         m_resv = 1; m_rdata = alu_ref(m_cur.a, m_cur.b, m_cur.cmd);
         m_rerr = 0; m_rtag = m_cur.tag;
      end
      if (p_pop) begin
         head  = m_q.pop_front();
         m_cur = head;
         m_out = 1;
         if (head.cmd == OP_DIV && head.b == 32'd0) begin
            m_resv = 1; m_rdata = 32'hFFFF_FFFF; m_rerr = 1; m_rtag = head.tag;
         end else begin
            m_start = 1;
         end
      end
      if (p_push) m_q.push_back(p_cmd);
      // ALU: sample operands on a start, deliver the result alu_lat edges later
      if (p_st) begin
         alu_busy = 1; alu_rem = alu_lat - 1;
         i_alu_result = alu_ref(p_a, p_b, p_c);
      end else if (p_alu_v) begin
         alu_busy = 0;
      end else if (alu_busy) begin
         alu_rem--;
      end
      i_alu_valid = alu_busy && (alu_rem == 0);
      i_alu_ready = !alu_busy && !alu_hold;
      if (o_alu_start) n_starts++;
      chk("count", 32'(o_count), 32'(m_q.size()));
      chk("ready", 32'(o_ready), 32'(m_q.size() < DEPTH));
      chk("start", 32'(o_alu_start), 32'(m_start));
      chk("res_valid", 32'(o_res_valid), 32'(m_resv));
      if (m_resv) begin
         chk("res_data", o_res_data, m_rdata);
         chk("res_tag", 32'(o_res_tag), 32'(m_rtag));
         chk("res_err", 32'(o_res_err), 32'(m_rerr));
      end
      if (m_out && !m_resv) begin
         chk("alu_a", o_alu_a, m_cur.a);
         chk("alu_b", o_alu_b, m_cur.b);
         chk("alu_cmd", 32'(o_alu_cmd), 32'(m_cur.cmd));
      end
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c, input logic [TAG_W-1:0] t);
      i_valid = 1; i_a = a; i_b = b; i_cmd = c; i_tag = t;
      tick();
      i_valid = 0;
   endtask

   task automatic drain(input int maxcyc);
      int k = 0;
      while ((m_q.size() != 0 || m_out) && k < maxcyc) begin
         tick();
         k++;
      end
      chk("drain_timeout", 32'(m_q.size() != 0 || m_out), 32'd0);
   endtask

   task automatic apply_reset();
      i_valid = 0;
      reset   = 0;
      #1;
      chk("rst_alu_a", o_alu_a, 32'd0);
      chk("rst_alu_b", o_alu_b, 32'd0);
      chk("rst_alu_cmd", 32'(o_alu_cmd), 32'd0);
      chk("rst_start", 32'(o_alu_start), 32'd0);
      chk("rst_res_valid", 32'(o_res_valid), 32'd0);
      chk("rst_res_data", o_res_data, 32'd0);
      chk("rst_res_tag", 32'(o_res_tag), 32'd0);
      chk("rst_res_err", 32'(o_res_err), 32'd0);
      chk("rst_count", 32'(o_count), 32'd0);
      m_q.delete(); m_out = 0; m_resv = 0; m_start = 0;
      tick();
      tick();
      reset = 1;
   endtask

   task automatic run_random(input int ncmd);
      int acc = 0;
      int k = 0;
      logic [2:0] op;
      hs_tags.delete();
      while (acc < ncmd && k < 2000) begin
         op          = 3'($urandom_range(0, 7));
         i_valid     = ($urandom_range(0, 1) == 1);
         i_a         = $urandom;
         i_cmd       = op;
         i_b         = (op == OP_DIV && $urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
         i_tag       = TAG_W'(acc);
         i_res_ready = ($urandom_range(0, 3) != 0);
         alu_lat     = $urandom_range(1, 4);
         tick();
         if (last_push_ok) acc++;
         k++;
      end
      i_valid = 0;
      i_res_ready = 1;
      chk("rnd_accepted", 32'(acc), 32'(ncmd));
      drain(500);
      chk("rnd_n_results", 32'(hs_tags.size()), 32'(ncmd));
      for (int i = 0; i < hs_tags.size() && i < ncmd; i++)
         chk("rnd_order", 32'(hs_tags[i]), 32'(i % (1 << TAG_W)));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, required normal finish");
      $fatal(1);
   end

   initial begin
      logic [31:0]      s_data;
      logic [TAG_W-1:0] s_tag;
      logic             s_err;
      int               k;
      i_valid = 0; i_a = '0; i_b = '0; i_cmd = '0; i_tag = '0;
      i_alu_valid = 0; i_alu_result = '0; i_res_ready = 1;
      alu_busy = 0; alu_hold = 0; alu_rem = 0; alu_lat = 2;
      i_alu_ready = 1;
      m_out = 0; m_resv = 0; m_start = 0;
      #2;
      apply_reset();

      // single ADD through a 2-cycle ALU
      n_starts = 0; hs_tags.delete();
      push(32'd7, 32'd5, OP_ADD, 4'd3);
      chk("t1_count", 32'(o_count), 32'd1);
      tick();
      chk("t1_start", 32'(o_alu_start), 32'd1);
      chk("t1_a", o_alu_a, 32'd7);
      chk("t1_b", o_alu_b, 32'd5);
      tick();
      chk("t1_start_drop", 32'(o_alu_start), 32'd0);
      drain(20);
      chk("t1_nstart", 32'(n_starts), 32'd1);
      chk("t1_data", last_data, 32'd12);
      chk("t1_tag", 32'(hs_tags[hs_tags.size()-1]), 32'd3);
      chk("t1_err", 32'(last_err), 32'd0);

      // fill while the ALU is not ready, then drain in order
      set_hold(1);
      for (int i = 0; i < 5; i++) push(32'(i * 3), 32'(i + 1), OP_ADD, TAG_W'(i));
      chk("t2_ready_full", 32'(o_ready), 32'd0);
      chk("t2_count_full", 32'(o_count), 32'd4);
      hs_tags.delete();
      set_hold(0);
      drain(100);
      chk("t2_n", 32'(hs_tags.size()), 32'd4);
      for (int i = 0; i < hs_tags.size() && i < 4; i++) chk("t2_order", 32'(hs_tags[i]), 32'(i));

      // divide by zero answered locally
      n_starts = 0; hs_tags.delete();
      push(32'd9, 32'd0, OP_DIV, 4'd1);
      tick();
      chk("t3_res_valid", 32'(o_res_valid), 32'd1);
      drain(20);
      chk("t3_nstart", 32'(n_starts), 32'd0);
      chk("t3_data", last_data, 32'hFFFF_FFFF);
      chk("t3_err", 32'(last_err), 32'd1);
      chk("t3_tag", 32'(hs_tags[hs_tags.size()-1]), 32'd1);

      // writeback stalls for 10 cycles while upstream keeps pushing
      i_res_ready = 0;
      push(32'd100, 32'd23, OP_SUB, 4'd5);
      k = 0;
      while (!o_res_valid && k < 20) begin tick(); k++; end
      chk("t4_in_hold", 32'(o_res_valid), 32'd1);
      s_data = o_res_data; s_tag = o_res_tag; s_err = o_res_err;
      n_starts = 0;
      for (int i = 0; i < 10; i++) begin
         i_valid = 1; i_a = $urandom; i_b = $urandom; i_cmd = OP_XOR; i_tag = TAG_W'(6 + i);
         tick();
         chk("t4_stable_data", o_res_data, s_data);
         chk("t4_stable_tag", 32'(o_res_tag), 32'(s_tag));
         chk("t4_stable_err", 32'(o_res_err), 32'(s_err));
      end
      i_valid = 0;
      chk("t4_nstart", 32'(n_starts), 32'd0);
      chk("t4_count", 32'(o_count), 32'd4);
      i_res_ready = 1;
      drain(200);

      // reset while BUSY; the stale ALU result must be ignored
      alu_lat = 6;
      push(32'd1, 32'd2, OP_ADD, 4'd7);
      tick();
      tick();
      apply_reset();
      for (int i = 0; i < 10; i++) tick();
      chk("t5_res_valid", 32'(o_res_valid), 32'd0);
      chk("t5_count", 32'(o_count), 32'd0);
      chk("t5_alu_a", o_alu_a, 32'd0);
      chk("t5_res_data", o_res_data, 32'd0);
      alu_lat = 2;
      for (int i = 0; i < 5; i++) tick();

      // push and pop on the same edge at count 2
      set_hold(1);
      push(32'd10, 32'd1, OP_SUB, 4'd0);
      push(32'd20, 32'd2, OP_SUB, 4'd1);
      chk("t6_count_before", 32'(o_count), 32'd2);
      i_valid = 1; i_a = 32'd30; i_b = 32'd3; i_cmd = OP_SUB; i_tag = 4'd2;
      set_hold(0);
      tick();
      i_valid = 0;
      chk("t6_count_same", 32'(o_count), 32'd2);
      drain(100);

      // pointer wrap with 12 commands, then longer random traffic
      run_random(12);
      run_random(40);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
